// File: rtl/fir_coeff_loader.sv
`timescale 1ns/1ps
// fir_coeff_loader
// Writer side of the FIR coefficient bank. A framed byte stream
// (0xA5, payload MSB-first per tap, XOR checksum) is assembled into a shadow
// bank, verified, then copied to the active bank on the next sample tick.
// Optional build macro: COEFF_LOADER_TIMEOUT_EN adds an inter-byte timeout
// that aborts a stalled frame while receiving payload.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | hunting for header 0xA5, other bytes dropped
// S_PAYLOAD | shifting payload bytes into shadow, then taking checksum
// S_CHECK   | one cycle: compare received checksum with running XOR
// S_PENDING | verified set waiting for tick_i to swap into active bank
module fir_coeff_loader #(
    parameter int NUM_COEFFS     = 23,
    parameter int COEFF_WIDTH    = 24,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          tick_i,
    input  logic [7:0]                    byte_i,
    input  logic                          byte_valid_i,
    output logic                          byte_ready_o,
    output logic signed [COEFF_WIDTH-1:0] coeff_o [NUM_COEFFS],
    output logic                          update_o,
    output logic                          busy_o,
    output logic                          chk_err_o,
    output logic [7:0]                    err_count_o
);
    localparam int BYTES_PER_COEFF = COEFF_WIDTH / 8;
    localparam int PAYLOAD_BYTES   = NUM_COEFFS * BYTES_PER_COEFF;
    localparam int IDX_W           = $clog2(PAYLOAD_BYTES + 1);
    localparam int TAP_W           = $clog2(NUM_COEFFS + 1);
    localparam int SUB_W           = $clog2(BYTES_PER_COEFF + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;
    localparam logic [1:0] S_PENDING = 2'd3;

    localparam logic [7:0] HEADER = 8'hA5;

    logic [1:0]                    r_state;
    logic [IDX_W-1:0]              r_idx;
    logic [TAP_W-1:0]              r_tap;
    logic [SUB_W-1:0]              r_sub;
    logic [7:0]                    r_chk;
    logic [7:0]                    r_rx_chk;
    logic [COEFF_WIDTH-1:0]        r_shadow [NUM_COEFFS];
    logic signed [COEFF_WIDTH-1:0] r_coeff [NUM_COEFFS];
    logic [7:0]                    r_err_count;

    logic w_take;
    logic w_hdr;
    logic w_chk_bad;
    logic w_swap;
    logic w_timeout;

    assign byte_ready_o = (r_state == S_IDLE) || (r_state == S_PAYLOAD);
    assign w_take       = byte_valid_i && byte_ready_o;
    assign w_hdr        = (r_state == S_IDLE) && w_take && (byte_i == HEADER);
    assign w_chk_bad    = (r_state == S_CHECK) && (r_rx_chk != r_chk);
    assign w_swap       = (r_state == S_PENDING) && tick_i;

    // Pulses are suppressed while reset is asserted because reset wins that edge.
    assign update_o    = reset_i && w_swap;
    assign chk_err_o   = reset_i && (w_chk_bad || w_timeout);
    assign busy_o      = (r_state != S_IDLE);
    assign err_count_o = r_err_count;
    assign coeff_o     = r_coeff;

`ifdef COEFF_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;

    // Inter-byte down-counter: reloaded on each payload byte, zero outside payload.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_to_cnt <= '0;
        end else if (w_hdr) begin
            r_to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
        end else if (r_state != S_PAYLOAD) begin
            r_to_cnt <= '0;
        end else if (w_take) begin
            r_to_cnt <= (r_idx == IDX_W'(PAYLOAD_BYTES)) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);
        end else if (r_to_cnt != '0) begin
            r_to_cnt <= r_to_cnt - TO_W'(1);
        end
    end

    assign w_timeout = (r_state == S_PAYLOAD) && !w_take && (r_to_cnt == '0);
`else
    // No timeout in this build; PAYLOAD waits indefinitely (constant false).
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // Frame FSM: header hunt, payload assembly into shadow, checksum, swap wait.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_tap    <= '0;
            r_sub    <= '0;
            r_chk    <= '0;
            r_rx_chk <= '0;
            for (int k = 0; k < NUM_COEFFS; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hdr) begin
                        r_state <= S_PAYLOAD;
                        r_idx   <= '0;
                        r_tap   <= '0;
                        r_sub   <= '0;
                        r_chk   <= '0;
                    end
                end
                S_PAYLOAD: begin
                    if (w_timeout) begin
                        r_state <= S_IDLE;
                    end else if (w_take) begin
                        if (r_idx == IDX_W'(PAYLOAD_BYTES)) begin
                            r_rx_chk <= byte_i;
                            r_state  <= S_CHECK;
                        end else begin
                            // Every tap receives exactly BYTES_PER_COEFF shifts,
                            // so stale contents are always fully overwritten.
                            r_shadow[r_tap] <= (r_shadow[r_tap] << 8) | COEFF_WIDTH'(byte_i);
                            r_chk           <= r_chk ^ byte_i;
                            r_idx           <= r_idx + IDX_W'(1);
                            if (r_sub == SUB_W'(BYTES_PER_COEFF - 1)) begin
                                r_sub <= '0;
                                r_tap <= r_tap + TAP_W'(1);
                            end else begin
                                r_sub <= r_sub + SUB_W'(1);
                            end
                        end
                    end
                end
                S_CHECK: begin
                    r_state <= (r_rx_chk == r_chk) ? S_PENDING : S_IDLE;
                end
                S_PENDING: begin
                    if (tick_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Active bank only changes on a tick edge so the filter never sees a mixed set.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int k = 0; k < NUM_COEFFS; k++) begin
                r_coeff[k] <= '0;
            end
        end else if (w_swap) begin
            for (int k = 0; k < NUM_COEFFS; k++) begin
                r_coeff[k] <= $signed(r_shadow[k]);
            end
        end
    end

    // Rejected-frame counter, saturating at 255.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_err_count <= '0;
        end else if ((w_chk_bad || w_timeout) && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_fir_coeff_loader.sv
`timescale 1ns/1ps
module tb_fir_coeff_loader;
    localparam int NC     = 23;
    localparam int CW     = 24;
    localparam int BPC    = CW / 8;
    localparam int TO     = 16;
    localparam int TICK_P = 37;

    logic                 clk_i = 1'b0;
    logic                 reset_i = 1'b0;
    logic                 tick_i = 1'b0;
    logic [7:0]           byte_i = 8'h00;
    logic                 byte_valid_i = 1'b0;
    logic                 byte_ready_o;
    logic signed [CW-1:0] coeff_o [NC];
    logic                 update_o;
    logic                 busy_o;
    logic                 chk_err_o;
    logic [7:0]           err_count_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_err = 0;

    int                upd_cyc_q[$];
    logic [NC*CW-1:0]  upd_val_q[$];
    int                err_cyc_q[$];
    int                err_val_q[$];

    logic signed [CW-1:0] taps [NC];

    fir_coeff_loader #(
        .NUM_COEFFS(NC),
        .COEFF_WIDTH(CW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .tick_i(tick_i),
        .byte_i(byte_i),
        .byte_valid_i(byte_valid_i),
        .byte_ready_o(byte_ready_o),
        .coeff_o(coeff_o),
        .update_o(update_o),
        .busy_o(busy_o),
        .chk_err_o(chk_err_o),
        .err_count_o(err_count_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_w(input string name, input logic [NC*CW-1:0] act, input logic [NC*CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [NC*CW-1:0] pack_dut();
        logic [NC*CW-1:0] v;
        for (int k = 0; k < NC; k++) v[k*CW +: CW] = coeff_o[k];
        return v;
    endfunction

    function automatic logic [NC*CW-1:0] pack_taps();
        logic [NC*CW-1:0] v;
        for (int k = 0; k < NC; k++) v[k*CW +: CW] = taps[k];
        return v;
    endfunction

    // Monitor: active-bank and error-count model driven only by expected events.
    initial begin : monitor
        logic [NC*CW-1:0] act_bank;
        logic [NC*CW-1:0] nxt_bank;
        int  mon_err;
        int  nxt_err;
        bit  upd_pend;
        bit  err_pend;
        act_bank = '0;
        nxt_bank = '0;
        mon_err  = 0;
        nxt_err  = 0;
        upd_pend = 0;
        err_pend = 0;
        forever begin
            @(negedge clk_i);
            if (!reset_i) begin
                act_bank = '0;
                mon_err  = 0;
                upd_pend = 0;
                err_pend = 0;
            end else begin
                if (upd_pend) act_bank = nxt_bank;
                if (err_pend) mon_err = nxt_err;
                upd_pend = 0;
                err_pend = 0;
                check_w("coeff_bank", pack_dut(), act_bank);
                check("err_count", err_count_o, mon_err);
                if (update_o) begin
                    check("update_expected", upd_cyc_q.size() > 0, 1);
                    if (upd_cyc_q.size() > 0) begin
                        check("update_cycle", cyc, upd_cyc_q.pop_front());
                        nxt_bank = upd_val_q.pop_front();
                        upd_pend = 1;
                    end
                end
                if (chk_err_o) begin
                    check("chk_err_expected", err_cyc_q.size() > 0, 1);
                    if (err_cyc_q.size() > 0) begin
                        check("chk_err_cycle", cyc, err_cyc_q.pop_front());
                        nxt_err  = err_val_q.pop_front();
                        err_pend = 1;
                    end
                end
            end
        end
    end

    task automatic advance();
        @(posedge clk_i);
        #1;
        tick_i = ((cyc % TICK_P) == 0);
        if (!byte_valid_i) byte_i = 8'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc);
        int n;
        n   = 0;
        acc = -1;
        byte_valid_i = 1'b1;
        byte_i       = b;
        while (acc < 0 && n < 64) begin
            if (byte_ready_o) acc = cyc;
            advance();
            n++;
        end
        byte_valid_i = 1'b0;
        if (acc < 0) check("byte_accept_bound", n, 0);
    endtask

    // Encodes taps[] as a frame; stop_after >= 0 stops after that many payload bytes.
    task automatic send_frame(input logic [7:0] flip, input int gap_max, input int stop_after,
                              output int last);
        logic [7:0]    x;
        logic [7:0]    b;
        logic [CW-1:0] t;
        int            acc;
        x = 8'h00;
        send_byte(8'hA5, acc);
        for (int k = 0; k < NC*BPC; k++) begin
            if (stop_after >= 0 && k == stop_after) begin
                last = acc;
                return;
            end
            repeat ($urandom_range(0, gap_max)) advance();
            t = taps[k/BPC];
            b = t[CW-1-8*(k%BPC) -: 8];
            x = x ^ b;
            send_byte(b, acc);
        end
        send_byte(x ^ flip, acc);
        last = acc;
    endtask

    // Called in the CHECK cycle (c+1) of a frame whose checksum was driven in cycle c.
    task automatic finish_good(input int c, input bit tick_in_check);
        int t0;
        t0 = c + 2;
        while ((t0 % TICK_P) != 0) t0++;
        upd_cyc_q.push_back(t0);
        upd_val_q.push_back(pack_taps());
        if (tick_in_check) begin
            tick_i = 1'b1;
            #1;
            check("no_swap_in_check", update_o, 0);
        end
        advance();
        check("pending_busy", busy_o, 1);
        check("pending_not_ready", byte_ready_o, 0);
        while (cyc <= t0 + 1) advance();
        check("swap_idle", busy_o, 0);
        check("upd_queue_drained", upd_cyc_q.size(), 0);
    endtask

    task automatic push_err(input int at_cyc);
        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        err_cyc_q.push_back(at_cyc);
        err_val_q.push_back(exp_err);
    endtask

    task automatic finish_bad(input int c);
        push_err(c + 1);
        advance();
        check("bad_idle", busy_o, 0);
        check("err_queue_drained", err_cyc_q.size(), 0);
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        upd_cyc_q.delete();
        upd_val_q.delete();
        err_cyc_q.delete();
        err_val_q.delete();
        exp_err = 0;
        advance();
        advance();
        reset_i = 1'b1;
    endtask

    task automatic random_taps();
        for (int k = 0; k < NC; k++) taps[k] = CW'($urandom);
    endtask

    task automatic fixed_taps();
        for (int k = 0; k < NC; k++) taps[k] = CW'((k - 11) * 1000);
        taps[0]  = '0;
        taps[1]  = '0;
        taps[2]  = -24'sd19348;
        taps[11] = 24'hA5A5A5;
        taps[20] = 24'sd19348;
        taps[21] = '0;
        taps[22] = '0;
    endtask

    initial begin : stim
        int          last;
        int          acc;
        logic [7:0]  flip;
        logic [7:0]  junk;
        logic [7:0]  jv [3];

        do_reset();
        check("rst_ready", byte_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_err_count", err_count_o, 0);
        check("rst_update", update_o, 0);
        check("rst_chk_err", chk_err_o, 0);
        check("rst_coeff2", coeff_o[2], 0);

        // Reference frame, with a tick landing in the CHECK cycle.
        fixed_taps();
        send_frame(8'h00, 2, -1, last);
        check("pre_swap_coeff2", coeff_o[2], 0);
        finish_good(last, 1'b1);
        check("tap2_loaded", coeff_o[2], -19348);
        check("tap11_hdr_as_data", coeff_o[11], -5921371);
        check("tap20_loaded", coeff_o[20], 19348);

        // Same frame, corrupted checksum.
        send_frame(8'h01, 2, -1, last);
        finish_bad(last);
        check("err_after_bad", err_count_o, 1);
        check("coeff2_kept", coeff_o[2], -19348);

        // Junk before a header is dropped silently.
        jv[0] = 8'h00;
        jv[1] = 8'hFF;
        jv[2] = 8'h12;
        for (int i = 0; i < 3; i++) begin
            send_byte(jv[i], acc);
            check("junk_not_busy", busy_o, 0);
        end
        random_taps();
        send_frame(8'h00, 1, -1, last);
        finish_good(last, 1'b0);

        // Reset after 30 payload bytes.
        fixed_taps();
        send_frame(8'h00, 1, 30, last);
        advance();
        check("midframe_busy", busy_o, 1);
        do_reset();
        check("reset_mid_busy", busy_o, 0);
        check("reset_mid_coeff2", coeff_o[2], 0);
        check("reset_mid_err", err_count_o, 0);
        send_frame(8'h00, 1, -1, last);
        finish_good(last, 1'b0);
        check("reload_tap2", coeff_o[2], -19348);

        // Stall after 10 payload bytes.
        random_taps();
        send_frame(8'h00, 0, 10, last);
`ifdef COEFF_LOADER_TIMEOUT_EN
        push_err(last + TO);
        repeat (20) advance();
        check("timeout_idle", busy_o, 0);
        check("timeout_err_drained", err_cyc_q.size(), 0);
        check("timeout_err_count", err_count_o, exp_err);
`else
        repeat (20) advance();
        check("stall_busy", busy_o, 1);
        check("stall_no_err", err_count_o, exp_err);
        do_reset();
`endif

        // Randomized frames.
        for (int i = 0; i < 20; i++) begin
            random_taps();
            repeat ($urandom_range(0, 2)) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk, acc);
                check("rand_junk_idle", busy_o, 0);
            end
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_frame(flip, 3, -1, last);
            if (flip == 8'h00) finish_good(last, 1'($urandom_range(0, 1)));
            else finish_bad(last);
        end

        // Error counter saturation.
        for (int i = 0; i < 260; i++) begin
            random_taps();
            send_frame(8'h80, 0, -1, last);
            finish_bad(last);
        end
        check("err_saturated", err_count_o, 255);

        random_taps();
        send_frame(8'h00, 0, -1, last);
        finish_good(last, 1'b0);
        check("sat_err_held", err_count_o, 255);

        advance();
        check("final_upd_q", upd_cyc_q.size(), 0);
        check("final_err_q", err_cyc_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
